// File: rtl/cim_ark_sbox_engine.sv
// rtl/cim_ark_sbox_engine.sv - per-round AddRoundKey collection and table lookup for the CIM AES RIO path
module cim_ark_sbox_engine #(
   parameter int NBYTES     = 16,
   parameter int LANES      = 2,
   parameter int LOOKUP_LAT = 1,
   parameter int NROUNDS    = 10
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                start,
   input  logic                in_vld,
   input  logic [LANES*8-1:0]  IN,
   input  logic                key_we,
   input  logic [3:0]          key_addr,
   input  logic [NBYTES*8-1:0] key_data,
   input  logic                tbl_we,
   input  logic [7:0]          tbl_addr,
   input  logic [7:0]          tbl_data,
   output logic [NBYTES*8-1:0] RIO,
   output logic                ark_vld,
   output logic                sbox_vld,
   output logic [3:0]          round,
   output logic                busy,
   output logic                done
);

   localparam int             NBEATS    = NBYTES / LANES;
   localparam int             BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BW-1:0]  LAST_BEAT = BW'(NBEATS - 1);
   localparam logic [2:0]     LAT_TERM  = 3'(LOOKUP_LAT - 1);
   localparam logic [3:0]     MAX_ROUND = 4'(NROUNDS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      LOOKUP  = 2'd2
   } state_t;

   state_t              state_q;
   logic [BW-1:0]       beat_q;
   logic [2:0]          lat_q;
   logic [3:0]          round_q;
   logic [NBYTES*8-1:0] rio_q;
   logic [NBYTES*8-1:0] addr_q;
   logic                ark_vld_q;
   logic                sbox_vld_q;
   logic                done_q;

   // Run-time loadable storage; deliberately left without reset
   logic [NBYTES*8-1:0] key_mem [0:NROUNDS];
   logic [7:0]          tbl_mem [0:255];

   logic [NBYTES*8-1:0] key_cur;
   logic [7:0]          ark_byte [NBYTES];
   logic [7:0]          lut_byte [NBYTES];

   assign key_cur = key_mem[round_q];

   // Candidate byte values: lane data XOR current key, and table result per stored address
   always_comb begin
      for (int k = 0; k < NBYTES; k++) begin
         ark_byte[k] = IN[LANES*8-1-8*(k%LANES) -: 8] ^ key_cur[NBYTES*8-1-8*k -: 8];
         lut_byte[k] = tbl_mem[addr_q[NBYTES*8-1-8*k -: 8]];
      end
   end

   // Key and table writes land at the edge, so the entry is visible the following cycle
   always_ff @(posedge CLK) begin
      if (key_we && (key_addr <= MAX_ROUND)) begin
         key_mem[key_addr] <= key_data;
      end
      if (tbl_we) begin
         tbl_mem[tbl_addr] <= tbl_data;
      end
   end

   // Round sequencer: collect beats, wait out the lookup latency, then swap in table results
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         lat_q      <= '0;
         round_q    <= '0;
         rio_q      <= '0;
         addr_q     <= '0;
         ark_vld_q  <= 1'b0;
         sbox_vld_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         ark_vld_q  <= 1'b0;
         sbox_vld_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= COLLECT;
                  round_q <= '0;
                  beat_q  <= '0;
               end
            end
            COLLECT: begin
               if (in_vld) begin
                  // only the bytes owned by this beat move; the rest keep last round's value
                  for (int k = 0; k < NBYTES; k++) begin
                     if (BW'(k / LANES) == beat_q) begin
                        rio_q[NBYTES*8-1-8*k -: 8]  <= ark_byte[k];
                        addr_q[NBYTES*8-1-8*k -: 8] <= ark_byte[k];
                     end
                  end
                  if (beat_q == LAST_BEAT) begin
                     state_q   <= LOOKUP;
                     lat_q     <= '0;
                     beat_q    <= '0;
                     ark_vld_q <= 1'b1;
                  end else begin
                     beat_q <= beat_q + BW'(1);
                  end
               end
            end
            LOOKUP: begin
               if (lat_q == LAT_TERM) begin
                  for (int k = 0; k < NBYTES; k++) begin
                     rio_q[NBYTES*8-1-8*k -: 8] <= lut_byte[k];
                  end
                  sbox_vld_q <= 1'b1;
                  beat_q     <= '0;
                  if (round_q == MAX_ROUND) begin
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     round_q <= round_q + 4'd1;
                     state_q <= COLLECT;
                  end
               end else begin
                  lat_q <= lat_q + 3'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign RIO      = rio_q;
   assign ark_vld  = ark_vld_q;
   assign sbox_vld = sbox_vld_q;
   assign round    = round_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_cim_ark_sbox_engine.sv
// tb/tb_cim_ark_sbox_engine.sv - scoreboard bench for cim_ark_sbox_engine in two configurations
module tb_cim_ark_sbox_engine;

   localparam logic [127:0] C1_IN   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K0      = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K1      = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] C1_ARK  = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] C1_SBOX = 128'h63cab7040953d051cd60e0e7ba70e18c;
   localparam logic [127:0] STALL_MID = 128'h0010203040506070cd60e0e7ba70e18c;
   localparam logic [127:0] KW_ARK  = 128'h00102030405060707766554433221100;
   localparam logic [127:0] KW_SBOX = 128'h63cab7040953d051f533fc1bc3938263;

   typedef struct {
      logic         is_sbox;
      logic [127:0] rio;
      logic [3:0]   rnd;
      logic         dn;
      int           cyc;
   } exp_t;

   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   logic key_we = 1'b0;
   logic [3:0] key_addr = '0;
   logic [127:0] key_data = '0;
   logic tbl_we = 1'b0;
   logic [7:0] tbl_addr = '0;
   logic [7:0] tbl_data = '0;

   logic a_start = 1'b0, a_vld = 1'b0;
   logic [15:0] a_in = '0;
   logic [127:0] a_rio;
   logic a_ark, a_sbox, a_busy, a_done;
   logic [3:0] a_round;

   logic b_start = 1'b0, b_vld = 1'b0;
   logic [31:0] b_in = '0;
   logic [127:0] b_rio;
   logic b_ark, b_sbox, b_busy, b_done;
   logic [3:0] b_round;

   exp_t qa[$];
   exp_t qb[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   cim_ark_sbox_engine #(.NBYTES(16), .LANES(2), .LOOKUP_LAT(1), .NROUNDS(10)) dut_a (
      .CLK(CLK), .RSTn(RSTn), .start(a_start), .in_vld(a_vld), .IN(a_in),
      .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .RIO(a_rio), .ark_vld(a_ark), .sbox_vld(a_sbox), .round(a_round),
      .busy(a_busy), .done(a_done)
   );

   cim_ark_sbox_engine #(.NBYTES(16), .LANES(4), .LOOKUP_LAT(3), .NROUNDS(10)) dut_b (
      .CLK(CLK), .RSTn(RSTn), .start(b_start), .in_vld(b_vld), .IN(b_in),
      .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .RIO(b_rio), .ark_vld(b_ark), .sbox_vld(b_sbox), .round(b_round),
      .busy(b_busy), .done(b_done)
   );

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   // forward AES S-box: GF(2^8) inverse (x^254) followed by the affine map
   function automatic logic [7:0] sbox_f(input logic [7:0] x);
      logic [7:0] r = 8'h01;
      logic [7:0] sq = x;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r = gmul(r, sq);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic push(input bit sel, input bit is_sbox, input logic [127:0] rio,
                       input logic [3:0] rnd, input bit dn, input int c);
      exp_t e;
      e.is_sbox = is_sbox;
      e.rio = rio;
      e.rnd = rnd;
      e.dn = dn;
      e.cyc = c;
      if (sel) qb.push_back(e);
      else qa.push_back(e);
   endtask

   task automatic monitor_one(input bit sel, input logic ark, input logic sbox, input logic dn,
                              input logic [127:0] rio, input logic [3:0] rnd);
      exp_t e;
      string p = sel ? "b" : "a";
      if (ark || sbox) begin
         if ((sel ? qb.size() : qa.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_pulse: got ark=%0b sbox=%0b rio=%0h, required no pulse",
                     p, ark, sbox, rio);
         end else begin
            if (sel) e = qb.pop_front();
            else e = qa.pop_front();
            chk({p, "_pulse_kind"}, {ark, sbox}, {!e.is_sbox, e.is_sbox});
            chk({p, "_rio"}, rio, e.rio);
            chk({p, "_round"}, rnd, e.rnd);
            chk({p, "_done"}, dn, e.dn);
            chk({p, "_cycle"}, cyc, e.cyc);
         end
      end else if (dn) begin
         checks++;
         errors++;
         $display("FAIL %s_done_alone: got done=1 without sbox_vld, required 0", p);
      end
   endtask

   always @(negedge CLK) begin
      monitor_one(1'b0, a_ark, a_sbox, a_done, a_rio, a_round);
      monitor_one(1'b1, b_ark, b_sbox, b_done, b_rio, b_round);
   end

   task automatic check_cleared(input bit sel, input string nm);
      chk({nm, "_rio"}, sel ? b_rio : a_rio, '0);
      chk({nm, "_busy"}, sel ? b_busy : a_busy, 1'b0);
      chk({nm, "_round"}, sel ? b_round : a_round, 4'd0);
      chk({nm, "_vld"}, sel ? {b_ark, b_sbox, b_done} : {a_ark, a_sbox, a_done}, 3'b000);
   endtask

   task automatic load_key(input logic [3:0] a, input logic [127:0] k);
      key_we = 1'b1; key_addr = a; key_data = k;
      @(posedge CLK); #1;
      key_we = 1'b0;
   endtask

   task automatic load_tbl(input bit ident);
      for (int i = 0; i < 256; i++) begin
         tbl_we = 1'b1;
         tbl_addr = 8'(i);
         tbl_data = ident ? 8'(i) : sbox_f(8'(i));
         @(posedge CLK); #1;
      end
      tbl_we = 1'b0;
   endtask

   task automatic do_reset();
      RSTn = 1'b0;
      repeat (2) @(posedge CLK);
      #2 RSTn = 1'b1;
      @(posedge CLK); #1;
   endtask

   // Streams one round; expectations are queued when the final beat is driven, then
   // in_vld is held high with junk for the lookup window, which the engine must ignore.
   task automatic stream(input bit sel, input logic [127:0] d, input logic [3:0] r,
                         input logic [127:0] x_ark, input logic [127:0] x_sbox, input bit want_sbox,
                         input int stall_at, input int stall_len, input bit kw);
      int nb = sel ? 4 : 8;
      int lat = sel ? 3 : 1;
      for (int b = 0; b < nb; b++) begin
         if (sel) begin b_vld = 1'b1; b_in = d[127-32*b -: 32]; end
         else begin a_vld = 1'b1; a_in = d[127-16*b -: 16]; end
         if (b == nb - 1) begin
            push(sel, 1'b0, x_ark, r, 1'b0, cyc + 1);
            if (want_sbox) push(sel, 1'b1, x_sbox, (r == 4'd10) ? 4'd10 : r + 4'd1, r == 4'd10, cyc + 1 + lat);
         end
         @(posedge CLK); #1;
         if (b == stall_at) begin
            if (sel) b_vld = 1'b0; else a_vld = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               if (kw && s == 0) begin key_we = 1'b1; key_addr = 4'd0; key_data = '1; end
               @(posedge CLK); #1;
               key_we = 1'b0;
            end
         end
      end
      if (sel) begin b_vld = 1'b1; b_in = '1; end
      else begin a_vld = 1'b1; a_in = '1; end
      repeat (lat) begin @(posedge CLK); #1; end
      if (sel) b_vld = 1'b0; else a_vld = 1'b0;
   endtask

   initial begin : stim
      logic [7:0] v;
      logic [127:0] d;
      repeat (3) @(posedge CLK);
      #1;
      check_cleared(1'b0, "a_reset");
      check_cleared(1'b1, "b_reset");
      RSTn = 1'b1;
      @(posedge CLK); #1;

      load_tbl(1'b0);
      load_key(4'd0, K0);
      load_key(4'd1, K1);
      for (int k = 2; k <= 10; k++) load_key(4'(k), K0);

      // FIPS-197 C.1 round 0 on both configurations side by side
      a_start = 1'b1; b_start = 1'b1;
      @(posedge CLK); #1;
      a_start = 1'b0; b_start = 1'b0;
      fork
         stream(1'b0, C1_IN, 4'd0, C1_ARK, C1_SBOX, 1'b1, -1, 0, 1'b0);
         stream(1'b1, C1_IN, 4'd0, C1_ARK, C1_SBOX, 1'b1, -1, 0, 1'b0);
      join
      repeat (2) @(posedge CLK); #1;

      // stall of 5 cycles between beats 3 and 4, round 1 with key1 set equal to key0
      load_key(4'd1, K0);
      fork
         stream(1'b0, C1_IN, 4'd1, C1_ARK, C1_SBOX, 1'b1, 3, 5, 1'b0);
         begin
            repeat (8) @(posedge CLK);
            #2 chk("a_stall_hold", a_rio, STALL_MID);
         end
      join
      repeat (2) @(posedge CLK); #1;

      // B: round 1, then reset in the middle of round 2 lookup
      stream(1'b1, C1_IN, 4'd1, C1_ARK, C1_SBOX, 1'b1, -1, 0, 1'b0);
      fork
         stream(1'b1, C1_IN, 4'd2, C1_ARK, C1_SBOX, 1'b0, -1, 0, 1'b0);
         begin
            repeat (5) @(posedge CLK);
            #3 RSTn = 1'b0;
            #1;
            check_cleared(1'b1, "b_midreset");
            check_cleared(1'b0, "a_midreset");
            repeat (3) @(posedge CLK);
            #2 RSTn = 1'b1;
         end
      join
      repeat (4) @(posedge CLK); #1;
      chk("b_after_reset_round", b_round, 4'd0);

      // key0 rewritten to all ones after beat 3 of round 0
      a_start = 1'b1;
      @(posedge CLK); #1;
      a_start = 1'b0;
      stream(1'b0, C1_IN, 4'd0, KW_ARK, KW_SBOX, 1'b1, 3, 1, 1'b1);
      repeat (2) @(posedge CLK); #1;

      // 11 rounds, zero keys, identity table; start mid-run must be ignored
      do_reset();
      for (int k = 0; k <= 10; k++) load_key(4'(k), '0);
      load_tbl(1'b1);
      a_start = 1'b1;
      @(posedge CLK); #1;
      a_start = 1'b0;
      d = '0;
      for (int r = 0; r <= 10; r++) begin
         v = 8'(r * 19 + 33);
         d = {8{v, ~v}};
         if (r == 3) begin
            fork
               stream(1'b0, d, 4'(r), d, d, 1'b1, -1, 0, 1'b0);
               begin
                  a_start = 1'b1;
                  @(posedge CLK); #1;
                  a_start = 1'b0;
               end
            join
         end else begin
            stream(1'b0, d, 4'(r), d, d, 1'b1, -1, 0, 1'b0);
         end
      end
      repeat (3) @(posedge CLK); #1;
      chk("a_final_busy", a_busy, 1'b0);
      chk("a_final_round", a_round, 4'd10);
      chk("a_final_rio", a_rio, d);
      a_vld = 1'b1; a_in = 16'h1234;
      repeat (3) @(posedge CLK); #1;
      a_vld = 1'b0;
      chk("a_idle_rio", a_rio, d);

      repeat (5) @(posedge CLK); #1;
      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

endmodule

// File: doc/cim_ark_sbox_engine.md
Name: cim_ark_sbox_engine

Overview:
- Synthesizable, parametrised engine for the CIM AES datapath; replaces the fixed 16-byte, 2-bytes-per-beat, 1-cycle-lookup bench model of the RIO return path.
- Each round: collects state bytes streamed on IN, XORs them with the current round key (AddRoundKey) and presents them on RIO, then replaces them with S-box outputs after a configurable lookup latency.
- Round keys and the S-box table are loadable at run time, so forward or inverse tables can be used. Sits between the AES controller IN port and the RIO inputs.

Parameters:
- NBYTES, 16, state bytes per round; must be a multiple of LANES.
- LANES, 2, bytes consumed per accepted IN beat (1, 2, 4, 8 or 16).
- LOOKUP_LAT, 1, cycles from end of collection to S-box result on RIO; must be 1 to 8.
- NROUNDS, 10, number of round keys after key 0; the round counter saturates here.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse in IDLE; clears the round counter to 0 and enters COLLECT.
- in_vld  in  1  IN beat valid; accepted only in COLLECT.
- IN  in  LANES*8  state bytes; MSB byte is the lowest byte index.
- key_we  in  1  round-key write strobe.
- key_addr  in  4  round-key index, 0..NROUNDS.
- key_data  in  NBYTES*8  round key; byte 0 is the MSB byte.
- tbl_we  in  1  S-box table write strobe.
- tbl_addr  in  8  table address.
- tbl_data  in  8  table entry.
- RIO  out  NBYTES*8  flat result bus; byte k is RIO[NBYTES*8-1-8k -: 8].
- ark_vld  out  1  one-cycle pulse: RIO holds the complete AddRoundKey result.
- sbox_vld  out  1  one-cycle pulse: RIO holds the S-box result.
- round  out  4  current round index.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse with the sbox_vld of round NROUNDS.

Behaviour:
- Reset: RIO=0, ark_vld=0, sbox_vld=0, done=0, busy=0, round=0, state=IDLE, beat counter=0, internal address registers=0. Key and table memories are not reset.
- Reset asserted mid-operation aborts immediately. After release the engine waits for a new start.
- States: IDLE -> (start) COLLECT -> (last beat accepted) LOOKUP -> (LOOKUP_LAT cycles elapsed) COLLECT for the next round, or IDLE after round NROUNDS.
- COLLECT, beat b accepted (in_vld=1):
  - For lane l, byte index k = b*LANES+l.
  - RIO byte k and addr[k] are set to IN byte l XOR key[round] byte k at the next edge.
  - Bytes not yet written keep their previous values.
- COLLECT stalls with no state change while in_vld=0.
- ark_vld pulses on the cycle after the final beat (b = NBYTES/LANES-1) is accepted.
- LOOKUP: a counter runs from 0 to LOOKUP_LAT-1. At its terminal edge every RIO byte k becomes tbl[addr[k]] simultaneously, and sbox_vld pulses in the following cycle.
- In that same edge round increments, saturating at NROUNDS, and the beat counter clears.
- If round was NROUNDS when the lookup finished: done pulses together with sbox_vld, the state returns to IDLE, and RIO holds its value.
- Total latency per round: NBYTES/LANES accepted beats, then LOOKUP_LAT cycles.
- in_vld outside COLLECT is ignored and no data is consumed.
- start while busy=1 is ignored.
- Key and table writes are allowed in any state and take effect the cycle after the write.
  - A key write to the current round during COLLECT affects only beats accepted after that write.
  - A table write during LOOKUP to an address being looked up yields the old entry if it lands on the terminal edge, and the new entry otherwise.
- key_addr > NROUNDS: the write is ignored.
- All XORs are bytewise with no width growth. The table address is exactly 8 bits.

Test Plan:
- FIPS-197 C.1, defaults:
  - Stimulus: load keys 0..10 (key0=000102030405060708090a0b0c0d0e0f, key1=d6aa74fdd2af72fadaa678f1d6ab76fe), load the forward S-box, start, stream 8 beats of 00112233445566778899aabbccddeeff.
  - Response: ark_vld with RIO=00102030405060708090a0b0c0d0e0f0, then after 1 cycle sbox_vld with RIO=63cab7040953d051cd60e0e7ba70e18c and round=1.
- LANES=4, LOOKUP_LAT=3:
  - Stimulus: same data as above.
  - Response: ark_vld after 4 beats; sbox_vld exactly 3 cycles after the last beat; same RIO values as above.
- Stall:
  - Stimulus: deassert in_vld for 5 cycles between beats 3 and 4.
  - Response: RIO bytes 8..15 hold their previous values; ark_vld is delayed by exactly 5 cycles; the result is unchanged.
- Saturation and completion:
  - Stimulus: run 11 rounds with all keys = 0 and an identity table.
  - Response: round stays at 10; done and sbox_vld coincide on round 10; state returns to IDLE; a start pulse while busy is ignored.
- Mid-operation reset:
  - Stimulus: assert RSTn=0 during LOOKUP of round 2.
  - Response: RIO=0, busy=0, round=0 asynchronously; no sbox_vld.
- Mid-collection key write:
  - Stimulus: write key0=ff..ff after beat 3.
  - Response: bytes 0..7 use the old key and bytes 8..15 use the new key.
